// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg -- channel count, select width and channel indices for stream_demux4
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package demux_pkg;
  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  localparam int CH0 = 0;
  localparam int CH1 = 1;
  localparam int CH2 = 2;
  localparam int CH3 = 3;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot -- one output channel: data register, valid bit, delivered counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux_slot #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic [SIZE-1:0]  in_data,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] count
);

  logic [SIZE-1:0]  data_q,  data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             deliver;

  assign deliver = valid_q && out_ready;

  // A load never coincides with flush because in_ready is forced low then.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (load) begin
      data_d = in_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (deliver) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/stream_demux4.sv
// ---------------------------------------------------------------------------
// stream_demux4 -- routes one valid/ready input stream to four buffered channels
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_demux4
  import demux_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [SIZE-1:0]   in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SIZE-1:0]   out_data0,
  output logic [SIZE-1:0]   out_data1,
  output logic [SIZE-1:0]   out_data2,
  output logic [SIZE-1:0]   out_data3,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic [CNT_W-1:0]  count2,
  output logic [CNT_W-1:0]  count3
);

  logic              accept;
  logic [CH_NUM-1:0] load;
  logic [SIZE-1:0]   slot_data  [CH_NUM];
  logic [CNT_W-1:0]  slot_count [CH_NUM];

  // A full slot still accepts when it is being drained in the same cycle.
  assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[in_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_slot
    demux_slot #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .load      (load[i]),
      .in_data   (in_data),
      .out_ready (out_ready[i]),
      .out_data  (slot_data[i]),
      .out_valid (out_valid[i]),
      .count     (slot_count[i])
    );
  end

  assign out_data0 = slot_data[CH0];
  assign out_data1 = slot_data[CH1];
  assign out_data2 = slot_data[CH2];
  assign out_data3 = slot_data[CH3];
  assign count0    = slot_count[CH0];
  assign count1    = slot_count[CH1];
  assign count2    = slot_count[CH2];
  assign count3    = slot_count[CH3];

endmodule

`default_nettype wire

// File: tb/tb_stream_demux4.sv
// ---------------------------------------------------------------------------
// tb_stream_demux4 -- directed stimulus with per-channel expected-word queues
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_demux4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  count0, count1, count2, count3;

  logic [31:0] od [4];
  logic [7:0]  oc [4];
  logic [31:0] exp_q [4][$];
  int          n_chk  = 0;
  int          n_pass = 0;

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;
  assign oc[0] = count0;
  assign oc[1] = count1;
  assign oc[2] = count2;
  assign oc[3] = count3;

  always #5 clk = ~clk;

  stream_demux4 #(.SIZE(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count0    (count0),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for one cycle; if acceptance is expected, queue it for the monitor.
  task automatic send(input logic [1:0] sel, input logic [31:0] data, input logic exp_rdy);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) exp_q[sel].push_back(data);
    step();
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  // Every delivery must match the oldest word queued for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_delivery ch%0d: got %h required none", i, od[i]);
          end else begin
            chk($sformatf("out_data%0d", i), od[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 32'd0;
    out_ready = 4'b0000;
    step();
    step();

    // Reset state
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_out_data%0d", i), od[i], 32'd0);
      chk($sformatf("rst_count%0d", i), {24'd0, oc[i]}, 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Pass-through on channel 2
    out_ready = 4'b1111;
    send(2'd2, 32'hDEADBEEF, 1'b1);
    in_valid = 1'b0;
    chk("pt_out_valid", {28'd0, out_valid}, 32'h4);
    chk("pt_out_data2", out_data2, 32'hDEADBEEF);
    chk("pt_count2_pre", {24'd0, count2}, 32'd0);
    step();
    chk("pt_count2", {24'd0, count2}, 32'd1);
    chk("pt_out_valid_clr", {28'd0, out_valid}, 32'd0);

    // Backpressure on channel 1, channel 3 keeps flowing
    out_ready = 4'b1101;
    send(2'd1, 32'h11, 1'b1);
    send(2'd1, 32'h22, 1'b0);
    chk("bp_out_data1", out_data1, 32'h11);
    send(2'd3, 32'h33, 1'b1);
    send(2'd1, 32'h22, 1'b0);
    chk("bp_out_data1_hold", out_data1, 32'h11);
    chk("bp_out_valid", {28'd0, out_valid}, 32'h2);
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    step();
    chk("bp_count1", {24'd0, count1}, 32'd1);
    chk("bp_count3", {24'd0, count3}, 32'd1);

    // Back-to-back stream on channel 0, delivery and accept overlap
    for (int k = 1; k <= 5; k++) send(2'd0, 32'(k), 1'b1);
    in_valid = 1'b0;
    step();
    chk("st_count0", {24'd0, count0}, 32'd5);

    // Flush with all slots full and no sink ready
    out_ready = 4'b0000;
    send(2'd0, 32'hA0, 1'b1);
    send(2'd1, 32'hA1, 1'b1);
    send(2'd2, 32'hA2, 1'b1);
    send(2'd3, 32'hA3, 1'b1);
    in_valid = 1'b0;
    chk("fl_full", {28'd0, out_valid}, 32'hF);
    flush = 1'b1;
    send(2'd0, 32'hBAD0, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    clear_q();
    chk("fl_out_valid", {28'd0, out_valid}, 32'd0);
    chk("fl_count0", {24'd0, count0}, 32'd5);
    chk("fl_count1", {24'd0, count1}, 32'd1);
    chk("fl_count2", {24'd0, count2}, 32'd1);
    chk("fl_count3", {24'd0, count3}, 32'd1);
    chk("fl_out_data3", out_data3, 32'hA3);
    // Flush must block an otherwise free, ready channel
    out_ready = 4'b1111;
    flush = 1'b1;
    send(2'd2, 32'hBAD2, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", {28'd0, out_valid}, 32'd0);

    // Counter wrap on channel 3 after a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_q();
    out_ready = 4'b1000;
    for (int k = 0; k < 256; k++) send(2'd3, 32'h300 + 32'(k), 1'b1);
    in_valid = 1'b0;
    chk("wr_count3_255", {24'd0, count3}, 32'd255);
    step();
    chk("wr_count3_0", {24'd0, count3}, 32'd0);

    // Asynchronous reset between clock edges
    out_ready = 4'b0010;
    send(2'd1, 32'hC1, 1'b1);
    in_valid = 1'b0;
    step();
    out_ready = 4'b0000;
    send(2'd1, 32'hB1, 1'b1);
    send(2'd3, 32'hB3, 1'b1);
    in_valid = 1'b0;
    chk("ar_pre_valid", {28'd0, out_valid}, 32'hA);
    chk("ar_pre_count1", {24'd0, count1}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {28'd0, out_valid}, 32'd0);
    chk("ar_out_data1", out_data1, 32'd0);
    chk("ar_out_data3", out_data3, 32'd0);
    chk("ar_count1", {24'd0, count1}, 32'd0);
    chk("ar_count3", {24'd0, count3}, 32'd0);
    clear_q();
    step();
    rst_n = 1'b1;
    out_ready = 4'b1111;
    send(2'd0, 32'hC0FFEE, 1'b1);
    in_valid = 1'b0;
    chk("ar_first_valid", {28'd0, out_valid}, 32'h1);
    step();
    chk("ar_first_count0", {24'd0, count0}, 32'd1);

    step();
    for (int i = 0; i < 4; i++) chk($sformatf("drain_ch%0d", i), exp_q[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux4.md
STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 SHALL have parameter SIZE, default 32, giving the data width of the input and every output channel.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of each per-channel delivered-word counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all output slots.
REQ-006 SHALL have port in_data, input, SIZE, the input word.
REQ-007 SHALL have port in_sel, input, 2, the destination channel 0..3.
REQ-008 SHALL have port in_valid, input, 1, asserted when the input word is offered.
REQ-009 SHALL have port in_ready, output, 1, asserted when the offered word is accepted this cycle.
REQ-010 SHALL have ports out_data0..out_data3, output, SIZE each, the channel words.
REQ-011 SHALL have port out_valid, output, 4, per-channel valid; bit i belongs to channel i.
REQ-012 SHALL have port out_ready, input, 4, per-channel sink ready.
REQ-013 SHALL have ports count0..count3, output, CNT_W each, words delivered on each channel.

Function
REQ-014 SHALL define input accept as in_valid && in_ready, and channel-i delivery as out_valid[i] && out_ready[i].
REQ-015 SHALL drive in_ready combinationally as !flush && (!out_valid[in_sel] || out_ready[in_sel]); in_ready does not depend on in_valid.
REQ-016 SHALL, on accept, load in_data into slot in_sel and set out_valid[in_sel] at the next edge: 1-cycle latency, no bubble.
REQ-017 SHALL, on delivery with no accept to the same channel, clear out_valid[i] at the next edge.
REQ-018 SHALL, on delivery and accept to the same channel in one cycle, replace the slot with the new word and keep out_valid[i]=1, with no lost or duplicated word.
REQ-019 SHALL leave channels other than in_sel unaffected by an accept; all four channels deliver independently and concurrently.
REQ-020 SHALL hold out_data[i] stable while out_valid[i]=1 and out_ready[i]=0.
REQ-021 SHALL increment count[i] by 1 on each channel-i delivery, wrapping modulo 2^CNT_W (all-ones goes to 0).
REQ-022 SHALL, when flush=1, clear all out_valid bits at the next edge, force in_ready=0, and leave counters and out_data unchanged; deliveries occurring in the flush cycle still count.
REQ-023 SHALL ignore in_data and in_sel when in_valid=0; out_data contents are don't-care when out_valid=0.

Reset
REQ-024 SHALL, while rst_n=0 and independent of clk, force out_valid=0, out_data0..3=0 and count0..3=0.
REQ-025 SHALL drop any word held or in transit when reset asserts mid-operation; the first accept after rst_n rises is handled normally on the next edge.

Structure
REQ-026 SHALL place the channel count (4), the select width (2) and the channel index constants in the shared package demux_pkg.
REQ-027 SHALL implement each channel as four instances of one sub-module, demux_slot, holding the data register, the valid bit and the counter; the top level contains only the select decode and the in_ready mux.

Verification
REQ-028 SHALL cover pass-through: out_ready=4'b1111, in_sel=2, in_data=32'hDEADBEEF accepted -> next cycle out_valid=4'b0100, out_data2=32'hDEADBEEF, count2 becomes 1 one cycle later.
REQ-029 SHALL cover backpressure: out_ready[1]=0, one word 32'h11 to channel 1, then in_sel=1 in_valid=1 -> in_ready=0, out_data1 stays 32'h11; with in_sel=3 the next word is accepted in the same cycles.
REQ-030 SHALL cover simultaneous delivery and accept on channel 0, streaming 32'h1..32'h5 back-to-back -> in_ready held 1, out_data0 sequence 1..5, count0=5.
REQ-031 SHALL cover counter wrap: 256 deliveries on channel 3 with CNT_W=8 -> count3 reads 255 then 0.
REQ-032 SHALL cover flush with all four slots full and out_ready=0 -> in_ready=0 during flush, out_valid=4'b0000 next cycle, counters unchanged.
REQ-033 SHALL cover asynchronous reset between edges with out_valid=4'b1010 -> outputs and counters 0 immediately, without waiting for a clk edge; self-checking PASS/FAIL report per check.
